// File: rtl/mfcc_pkg.sv
// mfcc_pkg
//   Shared constants and types for the MFCC front end (log stage and DCT).
//   Contents:
//     NUM_BANDS / IN_W / FRAC_W / LUT_BITS - pipeline geometry
//     LOG2_LUT  - 65-entry table, L[k] = round(log2(1 + k/64) * 1024)
//     q5_10_t   - signed Q5.10 log2 value carried to the DCT
//     lut_read  - bounded table read helper
package mfcc_pkg;

  localparam int NUM_BANDS = 40;
  localparam int IN_W      = 32;
  localparam int FRAC_W    = 10;
  localparam int LUT_BITS  = 6;
  localparam int LUT_SIZE  = (1 << LUT_BITS) + 1;
  localparam int BAND_W    = 6;

  typedef logic signed [15:0] q5_10_t;

  // Entry 64 is the top interpolation endpoint, so the table has 2^LUT_BITS + 1 entries.
  localparam logic [10:0] LOG2_LUT [LUT_SIZE] = '{
    11'd0,    11'd23,   11'd45,   11'd68,   11'd90,   11'd111,  11'd132,  11'd153,
    11'd174,  11'd194,  11'd214,  11'd234,  11'd254,  11'd273,  11'd292,  11'd311,
    11'd330,  11'd348,  11'd366,  11'd384,  11'd402,  11'd419,  11'd436,  11'd454,
    11'd470,  11'd487,  11'd504,  11'd520,  11'd536,  11'd552,  11'd568,  11'd584,
    11'd599,  11'd614,  11'd629,  11'd644,  11'd659,  11'd674,  11'd689,  11'd703,
    11'd717,  11'd731,  11'd745,  11'd759,  11'd773,  11'd787,  11'd800,  11'd813,
    11'd827,  11'd840,  11'd853,  11'd866,  11'd879,  11'd891,  11'd904,  11'd916,
    11'd929,  11'd941,  11'd953,  11'd965,  11'd977,  11'd989,  11'd1001, 11'd1012,
    11'd1024
  };

  function automatic logic [10:0] lut_read(input logic [6:0] k);
    return (k > 7'd64) ? 11'd0 : LOG2_LUT[k];
  endfunction

endpackage

// File: rtl/mel_log2_lzc32.sv
// lzc32
//   Combinational leading-one detector for a 32-bit word.
//   Ports:
//     data_i - word to scan
//     pos_o  - bit index of the most significant one (0 when data_i == 0)
//     nz_o   - high when data_i has at least one bit set
module lzc32 (
  input  logic [31:0] data_i,
  output logic [4:0]  pos_o,
  output logic        nz_o
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    pos_o = '0;
    for (int k = 0; k < 32; k++) begin
      if (data_i[k]) pos_o = 5'(k);
    end
  end

  assign nz_o = |data_i;

endmodule

// File: rtl/mel_log2.sv
// mel_log2
//   Log-compression stage of the MFCC pipeline. Converts each unsigned mel
//   energy into a Q5.10 log2 value through a 3-stage pipeline (normalise,
//   table lookup, linear interpolation) and tags it with its band index.
//   Ports:
//     clk, rst_n          - clock; synchronous active-high reset (1 = reset)
//     s_valid/s_ready     - input handshake
//     s_data, s_last      - energy and end-of-frame marker (band NUM_BANDS-1)
//     m_valid/m_ready     - output handshake towards the DCT
//     m_data              - Q5.10 log2 value, never negative
//     m_band, m_last      - band tag carried with the sample; last band flag
//     frame_err           - sticky framing error
module mel_log2
  import mfcc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [IN_W-1:0] s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [15:0]     m_data,
  output logic [5:0]      m_band,
  output logic            m_last,
  output logic            frame_err
);

  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

  logic              advance;
  logic              accept;
  logic [4:0]        leadPos;
  logic              nonZero;
  logic [31:0]       normWord;
  logic [11:0]       mantTop;
  logic [BAND_W-1:0] bandCnt_q, bandCnt_d;
  logic              err_q, err_d;

  logic              s1Valid_q;
  logic [4:0]        s1Exp_q;
  logic [5:0]        s1Idx_q, s1Rem_q;
  logic [BAND_W-1:0] s1Band_q;

  logic              s2Valid_q;
  logic [4:0]        s2Exp_q;
  logic [10:0]       s2Lo_q, s2Hi_q;
  logic [5:0]        s2Rem_q;
  logic [BAND_W-1:0] s2Band_q;

  logic              mValid_q;
  logic [15:0]       mData_q, mData_d;
  logic [BAND_W-1:0] mBand_q;
  logic              mLast_q;
  logic [16:0]       interp;
  logic [9:0]        frac;

  // The whole pipeline moves as one; a full output register blocks every stage.
  assign advance = !mValid_q || m_ready;
  assign s_ready = advance && !rst_n;
  assign accept  = s_valid && s_ready;

  lzc32 u_lzc (
    .data_i (s_data),
    .pos_o  (leadPos),
    .nz_o   (nonZero)
  );

  // Shifting left by 31-e puts the leading one at bit 31; the 12 bits below it
  // are the table index and interpolation weight. Short words shift in zeros.
  assign normWord = s_data << (~leadPos);
  assign mantTop  = nonZero ? 12'(normWord >> 19) : 12'd0;

  // Band counter resynchronises on any accepted s_last as well as on the last band.
  always_comb begin
    bandCnt_d = bandCnt_q;
    err_d     = err_q;
    if (accept) begin
      if (s_last != (bandCnt_q == LAST_BAND)) err_d = 1'b1;
      bandCnt_d = (s_last || bandCnt_q == LAST_BAND) ? '0 : bandCnt_q + 1'b1;
    end
  end

  // Interpolation step is at most 23, so the product never exceeds 17 bits.
  always_comb begin
    interp  = (17'(s2Hi_q - s2Lo_q) * 17'(s2Rem_q)) >> 6;
    frac    = 10'(17'(s2Lo_q) + interp);
    mData_d = {1'b0, s2Exp_q, frac};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      bandCnt_q <= '0;
      err_q     <= 1'b0;
      s1Valid_q <= 1'b0;
      s1Exp_q   <= '0;
      s1Idx_q   <= '0;
      s1Rem_q   <= '0;
      s1Band_q  <= '0;
      s2Valid_q <= 1'b0;
      s2Exp_q   <= '0;
      s2Lo_q    <= '0;
      s2Hi_q    <= '0;
      s2Rem_q   <= '0;
      s2Band_q  <= '0;
      mValid_q  <= 1'b0;
      mData_q   <= '0;
      mBand_q   <= '0;
      mLast_q   <= 1'b0;
    end else begin
      bandCnt_q <= bandCnt_d;
      err_q     <= err_d;
      if (advance) begin
        s1Valid_q <= accept;
        s1Exp_q   <= leadPos;
        s1Idx_q   <= mantTop[11:6];
        s1Rem_q   <= mantTop[5:0];
        s1Band_q  <= bandCnt_q;

        s2Valid_q <= s1Valid_q;
        s2Exp_q   <= s1Exp_q;
        s2Lo_q    <= lut_read({1'b0, s1Idx_q});
        s2Hi_q    <= lut_read({1'b0, s1Idx_q} + 7'd1);
        s2Rem_q   <= s1Rem_q;
        s2Band_q  <= s1Band_q;

        mValid_q  <= s2Valid_q;
        mData_q   <= mData_d;
        mBand_q   <= s2Band_q;
        mLast_q   <= (s2Band_q == LAST_BAND);
      end
    end
  end

  assign m_valid   = mValid_q;
  assign m_data    = mData_q;
  assign m_band    = mBand_q;
  assign m_last    = mLast_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_mel_log2.sv
// tb_mel_log2
//   Randomised bench for mel_log2 with a real-arithmetic log2 reference model.
module tb_mel_log2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic [5:0]  m_band;
  logic        m_last;
  logic        frame_err;

  typedef struct {
    logic [15:0] data;
    int          band;
    logic        last;
    int          acceptCyc;
  } expItem_t;

  expItem_t expQ[$];
  int       lutRef[65];
  int       vectors = 0;
  int       miscompares = 0;
  int       cyc = 0;
  int       modelBand = 0;
  int       lastOutCyc = 0;
  bit       latCheck = 0;
  bit       readyRandom = 0;
  logic     readyHold = 1'b1;

  mel_log2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_band    (m_band),
    .m_last    (m_last),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output-side consumer: either a fixed level or a coin flip each cycle.
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = readyRandom ? 1'($urandom_range(0, 1)) : readyHold;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: value = e + log2(1 + m) with m the fraction below the leading one,
  // approximated by linear interpolation between 64 table points.
  function automatic logic [15:0] refLog(input logic [31:0] x);
    longint v;
    longint f;
    int     e;
    int     i;
    int     r;
    int     fracVal;
    v = (x == 0) ? 64'd1 : longint'(x);
    e = 0;
    while (e < 31 && (v >> (e + 1)) != 0) e++;
    f = ((v - (longint'(1) << e)) * 4096) >> e;
    i = int'(f / 64);
    r = int'(f % 64);
    fracVal = lutRef[i] + ((lutRef[i + 1] - lutRef[i]) * r) / 64;
    return 16'(e * 1024 + fracVal);
  endfunction

  // Scoreboard: records accepted inputs, checks every presented output.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      expQ.delete();
      modelBand = 0;
    end else begin
      if (m_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousOutput", 32'(m_valid), 32'd0);
        end else begin
          checkOutput("m_data", 32'(m_data), 32'(expQ[0].data));
          checkOutput("m_band", 32'(m_band), 32'(expQ[0].band));
          checkOutput("m_last", 32'(m_last), 32'(expQ[0].last));
          if (m_ready) begin
            if (latCheck) checkOutput("latency", 32'(cyc - expQ[0].acceptCyc), 32'd3);
            lastOutCyc = cyc;
            void'(expQ.pop_front());
          end
        end
      end
      if (s_valid && s_ready) begin
        expQ.push_back('{refLog(s_data), modelBand, (modelBand == 39), cyc});
        modelBand = (s_last || modelBand == 39) ? 0 : modelBand + 1;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] d, input logic l);
    int   guard;
    logic acc;
    guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) checkOutput("acceptTimeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((expQ.size() != 0 || m_valid) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) checkOutput("drainTimeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] randEnergy();
    return $urandom >> $urandom_range(0, 31);
  endfunction

  initial begin
    int frameStart;
    logic [31:0] directed [6];
    for (int k = 0; k < 65; k++)
      lutRef[k] = int'($floor($ln(1.0 + real'(k) / 64.0) / $ln(2.0) * 1024.0 + 0.5));
    directed = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'd65536, 32'd0};

    // Values held while reset is asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_m_band", 32'(m_band), 32'd0);
    checkOutput("rst_m_last", 32'(m_last), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("s_ready_after_rst", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed values then a full back-to-back frame with the consumer always ready.
    latCheck = 1;
    frameStart = cyc;
    for (int b = 0; b < 40; b++)
      applyStimulus((b < 6) ? directed[b] : randEnergy(), b == 39);
    waitDrain();
    checkOutput("frameDrainCycles", 32'(lastOutCyc - frameStart), 32'd42);
    checkOutput("frame_err_clean", 32'(frame_err), 32'd0);
    latCheck = 0;

    // Three frames with random input gaps and a randomly stalling consumer.
    readyRandom = 1;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 40; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        applyStimulus(randEnergy(), b == 39);
      end
    end
    waitDrain();
    readyRandom = 0;
    readyHold = 1'b1;
    checkOutput("frame_err_stalls", 32'(frame_err), 32'd0);

    // Early s_last on band 20 flags an error and restarts the count.
    for (int b = 0; b <= 20; b++) applyStimulus(randEnergy(), b == 20);
    @(negedge clk);
    checkOutput("frame_err_set", 32'(frame_err), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(randEnergy(), 1'b0);
    waitDrain();
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("frame_err_sticky", 32'(frame_err), 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of a frame discards the pipeline and the error.
    for (int b = 0; b <= 10; b++) applyStimulus(randEnergy(), 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("midrst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    applyStimulus(32'd12345, 1'b0);
    waitDrain();
    checkOutput("post_rst_frame_err", 32'(frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mel_log2.md
# mel_log2

Log-compression stage of the MFCC pipeline: consumes the 40 per-frame mel-filterbank energies as an unsigned stream and produces one fixed-point log2 value per band, tagged with its band index, for the DCT stage directly downstream. It is a 3-stage valid/ready pipeline with 1 sample/cycle throughput: leading-zero normalisation, LUT lookup, then linear interpolation. It also carries a framing check on the 40-band frame structure.

## Interface
- NUM_BANDS, 40, mel bands per frame
- IN_W, 32, unsigned energy width
- FRAC_W, 10, fractional bits of log output
- LUT_BITS, 6, mantissa bits indexing LUT (65 entries)
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset; synchronous and active-high (asserted = 1)
- s_valid  in  1  input energy valid
- s_ready  out  1  stage can accept
- s_data  in  IN_W  unsigned mel energy
- s_last  in  1  marks band NUM_BANDS-1 of a frame
- m_valid  out  1  log value valid
- m_ready  in  1  DCT accepts
- m_data  out  16  signed Q5.10 log2 value, always >= 0
- m_band  out  6  band index 0..NUM_BANDS-1
- m_last  out  1  m_band == NUM_BANDS-1
- frame_err  out  1  sticky framing error

## Operation
- Input transfer when s_valid && s_ready; output transfer when m_valid && m_ready.
- Input band counter tags each accepted sample (0..NUM_BANDS-1); tag travels with data.
- Stage 1: e = index of leading one (0..31); mantissa = s_data << (31-e), drop leading one; i = top LUT_BITS bits, r = next 6 bits (zero-filled when e < 12).
- Stage 2: fetch L[i], L[i+1]; L[k] = round(log2(1+k/64)*1024), L[0]=0, L[64]=1024.
- Stage 3: frac = L[i] + (((L[i+1]-L[i]) * r) >> 6), truncating; m_data = {1'b0, e[4:0], frac[9:0]}.
- s_data == 0: m_data = 0 (same as input 1); no flag.
- Framing: s_last accepted with tag != NUM_BANDS-1, or tag == NUM_BANDS-1 accepted without s_last, sets frame_err (sticky until reset). Counter returns to 0 after any accepted s_last and after tag NUM_BANDS-1, so the stream resynchronises on s_last.
- m_last derived from carried tag, not from s_last.

## Timing
- Reset values: m_valid 0, m_data 0, m_band 0, m_last 0, frame_err 0, band counter 0, all stage valids 0; s_ready 0 while reset asserted, 1 the cycle after.
- Latency: input accepted in cycle N appears on m_valid in cycle N+3 with m_ready high.
- Pipeline advance enable = !m_valid || m_ready; s_ready = enable (combinational from m_ready); all stages hold while stalled; no data lost or duplicated.
- m_data/m_band/m_last stable while m_valid && !m_ready.
- Back-to-back: 40 samples of one frame drain in 40 cycles + 3.
- Reset mid-frame: pipeline contents discarded, counter to 0, frame_err cleared; next accepted sample is band 0.

## Structure
- mfcc_pkg: NUM_BANDS, IN_W, FRAC_W, LUT_BITS, log2 LUT constant (65 x 11-bit), Q5.10 output typedef; shared with DCT.
- Sub-module lzc32: combinational leading-one position + valid-nonzero flag.

## Test plan
- Reset, then s_data = 1, 2, 3 -> m_data 0, 1024, 1623 at band 0,1,2, each 3 cycles after acceptance.
- s_data = 0xFFFFFFFF -> 32767; s_data = 65536 -> 16384; s_data = 0 -> 0.
- Full 40-band frame with s_last on band 39, m_ready held 1 -> 40 outputs on consecutive cycles, m_last only on band 39, frame_err 0.
- Random m_ready toggling (~50%) over 3 frames -> output sequence identical to stall-free run, values stable while stalled.
- s_last on band 20 -> frame_err = 1 and stays 1; next sample tagged band 0.
- Reset asserted after band 10 accepted -> m_valid 0 next cycle; subsequent sample emitted as band 0, frame_err 0.
